reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port MIPS register file with busy-bit scoreboard. NRD comb read ports,
//  NWR sync write ports, register 0 hardwired zero, async clear on reset. Sits in decode
//  (reads/issue) and writeback (writes); Read_busy drives the decode stall logic.
// PARAMETERS
//  W      32  data width in bits
//  DEPTH  32  number of registers (power of 2, >=2); AW = $clog2(DEPTH)
//  NRD    2   number of read ports
//  NWR    2   number of write ports; higher index has priority
// PORTS
//  Clk        in   1        clock, all state updates on rising edge
//  Rst        in   1        asynchronous, active-high reset
//  Read_reg   in   NRD*AW   read addresses; port i = bits [i*AW +: AW]
//  Read_data  out  NRD*W    read data; port i = bits [i*W +: W]
//  Read_busy  out  NRD      port i target has a pending write (scoreboard bit)
//  Wr_en      in   NWR      write enable per write port
//  Wr_reg     in   NWR*AW   write addresses
//  Wr_data    in   NWR*W    write data
//  Issue_en   in   1        mark Issue_reg pending (instruction with destination issued)
//  Issue_reg  in   AW       destination being issued
//  Issue_busy out  1        Issue_reg already pending (WAW hazard), combinational
// BEHAVIOUR
//  - Reset (async, while Rst=1): all registers = 0, all busy bits = 0; Read_data = 0,
//    Read_busy = 0, Issue_busy = 0 for every address. Rst mid-operation discards pending
//    writes/issues of that edge; first update is the first rising edge after Rst falls.
//  - Read: combinational, zero latency. Address 0 always reads 0, busy 0.
//  - Write: on rising edge, for each port with Wr_en=1 and Wr_reg!=0, reg <= Wr_data.
//    Two ports same address same cycle: highest port index wins. Writes to 0 dropped.
//  - Scoreboard: busy[r] set at edge when Issue_en=1, Issue_reg=r!=0. Cleared at edge when
//    any write port writes r. Issue and write to same r in same cycle: busy stays 1
//    (newer issue wins). Issue to 0 ignored. Issue to already-busy r: stays 1, no error;
//    decode must stall on Issue_busy.
//  - Read_busy[i] = busy[Read_reg_i]; Issue_busy = busy[Issue_reg]; both reflect
//    registered state (no bypass of same-cycle issue/write).
//  - No wrap/overflow: one busy bit per register, no counts.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a read whose address matches a same-cycle active write
//   (Wr_en=1, Wr_reg!=0) returns that Wr_data (highest matching port), and Read_busy for
//   that port reads 0 unless a same-cycle Issue to it is also present.
//  Not defined: reads return the pre-edge stored value; Read_busy = stored busy bit.
//   Pipeline then needs the write-first-half/read-second-half or an extra stall cycle.
// STRUCTURE
//  - Package reg_pkg: REG_AW / REG_W defaults, REG_ZERO = 0 constant, typedef reg_idx_t.
//  - Sub-module reg_scoreboard (DEPTH busy bits, set/clear logic, Issue_busy/Read_busy
//    lookup); storage array, write-priority and bypass muxes stay in reg_file_mp.
// TESTING
//  1. Rst=1 then release; read all 32 addresses -> Read_data=0, Read_busy=0.
//  2. Wr_en=01, Wr_reg0=5, Wr_data0=0xDEADBEEF; next cycle Read_reg0=5 -> 0xDEADBEEF;
//     write 0x1234 to reg 0 -> reads 0.
//  3. Same edge Wr_en=11, both Wr_reg=7, data 0xAAAA/0x5555 -> reg 7 reads 0x5555.
//  4. Issue reg 9 -> Read_busy=1 next cycle; write reg 9 -> busy 0; same-cycle issue+write
//     reg 9 -> busy stays 1, Issue_busy=1 for Issue_reg=9.
//  5. Bypass: Wr reg 3=0x42 while Read_reg1=3 -> 0x42 same cycle with REGFILE_BYPASS_EN,
//     old value (0) without.
//  6. Assert Rst between edges with reg 4=0x99 and busy[4]=1 -> immediately reads 0, busy 0.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared constants and types for the multi-port register file.
// Optional feature macro used by reg_file_mp: REGFILE_BYPASS_EN.
package reg_pkg;

    localparam int REG_W  = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] reg_idx_t;

    // True when the index addresses the hardwired-zero register
    function automatic logic is_zero_idx(input reg_idx_t idx);
        return (idx == REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between decode/writeback logic (master) and the register file (slave).
interface reg_file_mp_if
    import reg_pkg::*;
#(
    parameter int W     = REG_W,
    parameter int DEPTH = 2**REG_AW,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NRD*AW-1:0] Read_reg;
    logic [NRD*W-1:0]  Read_data;
    logic [NRD-1:0]    Read_busy;
    logic [NWR-1:0]    Wr_en;
    logic [NWR*AW-1:0] Wr_reg;
    logic [NWR*W-1:0]  Wr_data;
    logic              Issue_en;
    logic [AW-1:0]     Issue_reg;
    logic              Issue_busy;

    modport master (
        output Read_reg, Wr_en, Wr_reg, Wr_data, Issue_en, Issue_reg,
        input  Read_data, Read_busy, Issue_busy
    );

    modport slave (
        input  Read_reg, Wr_en, Wr_reg, Wr_data, Issue_en, Issue_reg,
        output Read_data, Read_busy, Issue_busy
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per register, set on issue,
// cleared on writeback, newer issue wins over a same-edge writeback.
module reg_scoreboard #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_issue_en,
    input  logic [AW-1:0]     i_issue_reg,
    input  logic [NWR-1:0]    i_wr_en,
    input  logic [NWR*AW-1:0] i_wr_reg,
    input  logic [NRD*AW-1:0] i_read_reg,
    output logic [NRD-1:0]    o_read_busy,
    output logic              o_issue_busy
);

    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [DEPTH-1:0] w_clr;
    logic [NRD-1:0]   w_read_busy;

    // Next busy state: issue sets, any write port clears, issue beats clear
    always_comb begin
        w_clr      = {DEPTH{1'b0}};
        w_busy_nxt = {DEPTH{1'b0}};
        for (int r = 1; r < DEPTH; r++) begin
            for (int p = 0; p < NWR; p++) begin
                w_clr[r] = w_clr[r] | (i_wr_en[p] & (i_wr_reg[p*AW +: AW] == AW'(r)));
            end
            w_busy_nxt[r] = (i_issue_en & (i_issue_reg == AW'(r))) | (r_busy[r] & ~w_clr[r]);
        end
    end

    // Busy-bit register, cleared asynchronously on reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= {DEPTH{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Per-read-port lookup of the stored busy bit (register 0 is never busy)
    always_comb begin
        w_read_busy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            w_read_busy[i] = (i_read_reg[i*AW +: AW] == ZERO_IDX) ? 1'b0
                                                                   : r_busy[i_read_reg[i*AW +: AW]];
        end
    end

    assign o_read_busy  = w_read_busy;
    assign o_issue_busy = (i_issue_reg == ZERO_IDX) ? 1'b0 : r_busy[i_issue_reg];

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with busy-bit scoreboard: NRD combinational read
// ports, NWR synchronous write ports (highest index wins), register 0 reads 0.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module reg_file_mp
    import reg_pkg::*;
#(
    parameter int W     = REG_W,
    parameter int DEPTH = 2**REG_AW,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic         Clk,
    input  logic         Rst,
    reg_file_mp_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

    logic [W-1:0]     r_regs [DEPTH];
    logic [NRD-1:0]   w_sb_read_busy;
    logic             w_sb_issue_busy;
    logic [NRD*W-1:0] w_read_data;
    logic [NRD-1:0]   w_read_busy;
    logic [AW-1:0]    w_addr;
    logic [W-1:0]     w_data;
    logic             w_busy;
`ifdef REGFILE_BYPASS_EN
    logic             w_hit;
    logic             w_match;
`endif

    reg_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .i_clk        (Clk),
        .i_rst        (Rst),
        .i_issue_en   (bus.Issue_en),
        .i_issue_reg  (bus.Issue_reg),
        .i_wr_en      (bus.Wr_en),
        .i_wr_reg     (bus.Wr_reg),
        .i_read_reg   (bus.Read_reg),
        .o_read_busy  (w_sb_read_busy),
        .o_issue_busy (w_sb_issue_busy)
    );

    // Register storage; later write ports override earlier ones on a shared address
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_regs[r] <= {W{1'b0}};
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (bus.Wr_en[p] && (bus.Wr_reg[p*AW +: AW] != ZERO_IDX)) begin
                    r_regs[bus.Wr_reg[p*AW +: AW]] <= bus.Wr_data[p*W +: W];
                end
            end
        end
    end

    // Read ports: stored value, optional same-cycle write forwarding, zero for register 0
    always_comb begin
        w_read_data = {NRD*W{1'b0}};
        w_read_busy = {NRD{1'b0}};
        w_addr      = ZERO_IDX;
        w_data      = {W{1'b0}};
        w_busy      = 1'b0;
`ifdef REGFILE_BYPASS_EN
        w_hit       = 1'b0;
        w_match     = 1'b0;
`endif
        for (int i = 0; i < NRD; i++) begin
            w_addr = bus.Read_reg[i*AW +: AW];
            w_data = r_regs[w_addr];
            w_busy = w_sb_read_busy[i];
`ifdef REGFILE_BYPASS_EN
            w_hit = 1'b0;
            for (int p = 0; p < NWR; p++) begin
                w_match = bus.Wr_en[p] & (bus.Wr_reg[p*AW +: AW] == w_addr) & (w_addr != ZERO_IDX);
                w_data  = w_match ? bus.Wr_data[p*W +: W] : w_data;
                w_hit   = w_hit | w_match;
            end
            // A forwarded write retires the pending bit unless a newer issue lands on it
            w_busy = w_hit ? (bus.Issue_en & (bus.Issue_reg == w_addr)) : w_busy;
`endif
            w_data = (w_addr == ZERO_IDX) ? {W{1'b0}} : w_data;
            w_busy = (w_addr == ZERO_IDX) ? 1'b0 : w_busy;
            w_read_data[i*W +: W] = w_data;
            w_read_busy[i]        = w_busy;
        end
    end

    assign bus.Read_data  = w_read_data;
    assign bus.Read_busy  = w_read_busy;
    assign bus.Issue_busy = w_sb_issue_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: vector table plus hand-written
// sequences for write/issue collisions, forwarding and mid-cycle reset.
module tb_reg_file_mp;
    import reg_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [1:0]  wr_en;
        logic [4:0]  wr_reg0;
        logic [31:0] wr_data0;
        logic [4:0]  wr_reg1;
        logic [31:0] wr_data1;
        logic        issue_en;
        logic [4:0]  issue_reg;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic [1:0]  exp_rb;
        logic        exp_ib;
    } vec_t;

    logic Clk;
    logic Rst;
    int   checks;
    int   errors;
    vec_t exp_q[$];
    vec_t vecs[14];

    reg_file_mp_if #(.W(32), .DEPTH(32), .NRD(2), .NWR(2)) bus ();

    reg_file_mp #(.W(32), .DEPTH(32), .NRD(2), .NWR(2)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] r0, input logic [31:0] d0,
                                input logic [4:0] r1, input logic [31:0] d1,
                                input logic ie, input logic [4:0] ir,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] erb, input logic eib);
        vec_t v;
        v.wr_en = we; v.wr_reg0 = r0; v.wr_data0 = d0; v.wr_reg1 = r1; v.wr_data1 = d1;
        v.issue_en = ie; v.issue_reg = ir; v.rd0 = a0; v.rd1 = a1;
        v.exp_d0 = e0; v.exp_d1 = e1; v.exp_rb = erb; v.exp_ib = eib;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.Wr_en     = v.wr_en;
        bus.Wr_reg    = {v.wr_reg1, v.wr_reg0};
        bus.Wr_data   = {v.wr_data1, v.wr_data0};
        bus.Issue_en  = v.issue_en;
        bus.Issue_reg = v.issue_reg;
        bus.Read_reg  = {v.rd1, v.rd0};
    endtask

    task automatic check_out(input string nm);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard queue empty", nm);
        end else begin
            e = exp_q.pop_front();
            cmp({nm, ".rd0"}, bus.Read_data[31:0], e.exp_d0);
            cmp({nm, ".rd1"}, bus.Read_data[63:32], e.exp_d1);
            cmp({nm, ".rbusy"}, {30'd0, bus.Read_busy}, {30'd0, e.exp_rb});
            cmp({nm, ".ibusy"}, {31'd0, bus.Issue_busy}, {31'd0, e.exp_ib});
        end
    endtask

    // Drive one vector on the falling edge, check outputs before the next rising edge
    task automatic apply(input vec_t v, input string nm);
        @(negedge Clk);
        drive(v);
        exp_q.push_back(v);
        #2;
        check_out(nm);
    endtask

    vec_t idle_v;
    vec_t tmp_v;

    initial begin
        checks = 0;
        errors = 0;
        Rst    = 1'b1;
        idle_v = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
        drive(idle_v);

        vecs[0]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
        vecs[1]  = mk(2'b01, 5'd0, 32'h00001234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0);
        vecs[2]  = mk(2'b11, 5'd7, 32'h0000AAAA, 5'd7, 32'h00005555, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0);
        vecs[3]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 5'd0, 32'h00005555, 32'h0, 2'b00, 1'b0);
        vecs[4]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9, 5'd7, 32'h0, 32'h00005555, 2'b01, 1'b1);
        vecs[5]  = mk(2'b10, 5'd0, 32'h0, 5'd9, 32'h00000900, 1'b0, 5'd9, 5'd5, 5'd7, 32'hDEADBEEF, 32'h00005555, 2'b00, 1'b1);
        vecs[6]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9, 5'd0, 32'h00000900, 32'h0, 2'b00, 1'b0);
        vecs[7]  = mk(2'b01, 5'd9, 32'h00000999, 5'd0, 32'h0, 1'b1, 5'd9, 5'd5, 5'd7, 32'hDEADBEEF, 32'h00005555, 2'b00, 1'b0);
        vecs[8]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9, 5'd5, 32'h00000999, 32'hDEADBEEF, 2'b01, 1'b1);
        vecs[9]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h00000999, 2'b10, 1'b0);
        vecs[10] = mk(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
        vecs[11] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd5, 5'd7, 32'hDEADBEEF, 32'h00005555, 2'b00, 1'b1);
        vecs[12] = mk(2'b11, 5'd20, 32'h00000020, 5'd21, 32'h00000021, 1'b0, 5'd9, 5'd9, 5'd5, 32'h00000999, 32'hDEADBEEF, 2'b01, 1'b1);
        vecs[13] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd20, 5'd21, 32'h00000020, 32'h00000021, 2'b00, 1'b0);

        // Reset state, checked after release for every address
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            tmp_v = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'(a), 5'(a), 5'(31 - a), 32'h0, 32'h0, 2'b00, 1'b0);
            apply(tmp_v, $sformatf("reset_a%0d", a));
        end

        // Vector table
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Same-cycle write and read of register 3: forwarded only with bypass
        apply(mk(2'b01, 5'd3, 32'h00000042, 5'd0, 32'h0, 1'b0, 5'd3, 5'd5, 5'd3,
                 32'hDEADBEEF, BYP ? 32'h00000042 : 32'h0, 2'b00, 1'b0), "byp_wr");
        apply(mk(2'b10, 5'd0, 32'h0, 5'd3, 32'h00000043, 1'b1, 5'd3, 5'd3, 5'd0,
                 BYP ? 32'h00000043 : 32'h00000042, 32'h0, BYP ? 2'b01 : 2'b00, 1'b0), "byp_issue");
        apply(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3, 5'd0,
                 32'h00000043, 32'h0, 2'b01, 1'b1), "byp_after");

        // Mid-cycle reset with reg 4 written and pending
        apply(mk(2'b01, 5'd4, 32'h00000099, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0,
                 32'h0, 32'h0, 2'b00, 1'b0), "rst_setup");
        apply(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd4, 5'd4,
                 32'h00000099, 32'h00000099, 2'b11, 1'b1), "rst_pre");
        #1;
        Rst = 1'b1;
        #1;
        exp_q.push_back(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd4, 5'd9,
                           32'h0, 32'h0, 2'b00, 1'b0));
        bus.Read_reg = {5'd9, 5'd4};
        #1;
        check_out("rst_mid");
        // Writes and issues presented across an edge while reset is held are discarded
        drive(mk(2'b01, 5'd4, 32'h00000077, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4,
                 32'h0, 32'h0, 2'b00, 1'b0));
        @(posedge Clk);
        @(negedge Clk);
        drive(idle_v);
        Rst = 1'b0;
        apply(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd4, 5'd5,
                 32'h0, 32'h0, 2'b00, 1'b0), "rst_held");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
